// File: rtl/datapath_unit.sv
// -----------------------------------------------------------------------------
// datapath_unit
//   Execution datapath for the CPU: 8-entry register file, A/B operand
//   registers, single-position shifter, 4-function ALU, result register C and
//   Z/N/V status flags. All sequencing comes from the external controller via
//   the strobe inputs; the datapath itself has no FSM.
//
//   Optional feature macro: DATAPATH_OVF_EN
//     defined   -> V flag computed and captured on loads
//     undefined -> V flag register removed, V_out tied to 0
//
// Parameters
//   W             datapath width (register file fixed at 8 entries)
// Ports
//   clk           clock, all state updates on posedge
//   reset_n       asynchronous active-low reset, clears every register
//   nsel          one-hot index select: 100=rn, 010=rd, 001=rm, else R0
//   rn, rd, rm    register indices from the decoded instruction
//   vsel          write-back source: 00=C, 01=sximm8, 10=mdata, 11=pc
//   write         register file write strobe
//   loada, loadb  capture R[index] into A / B
//   asel, bsel    ALU Ain=0 when asel, Bin=sximm5 when bsel
//   shift         00=none, 01=LSL1, 10=LSR1, 11=ASR1
//   aluop         00=ADD, 01=SUB, 10=AND, 11=NOT Bin
//   loadc, loads  capture ALU result into C / flags into status
//   sximm8        sign-extended 8-bit immediate
//   sximm5        sign-extended 5-bit immediate
//   mdata         memory read data
//   pc            8-bit program counter
//   datapath_out  contents of C
//   Z_out, N_out, V_out  status flags
// -----------------------------------------------------------------------------
module datapath_unit #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [2:0]   nsel,
  input  logic [2:0]   rn,
  input  logic [2:0]   rd,
  input  logic [2:0]   rm,
  input  logic [1:0]   vsel,
  input  logic         write,
  input  logic         loada,
  input  logic         loadb,
  input  logic         asel,
  input  logic         bsel,
  input  logic [1:0]   shift,
  input  logic [1:0]   aluop,
  input  logic         loadc,
  input  logic         loads,
  input  logic [W-1:0] sximm8,
  input  logic [W-1:0] sximm5,
  input  logic [W-1:0] mdata,
  input  logic [7:0]   pc,
  output logic [W-1:0] datapath_out,
  output logic         Z_out,
  output logic         N_out,
  output logic         V_out
);

  function automatic logic signed [W-1:0] shift_f(input logic [1:0] op,
                                                   input logic signed [W-1:0] b);
    case (op)
      2'b01:   shift_f = {b[W-2:0], 1'b0};
      2'b10:   shift_f = {1'b0, b[W-1:1]};
      2'b11:   shift_f = {b[W-1], b[W-1:1]};
      default: shift_f = b;
    endcase
  endfunction

  // ADD/SUB wrap modulo 2^W; the carry out is discarded.
  function automatic logic signed [W-1:0] alu_f(input logic [1:0] op,
                                                 input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
    case (op)
      2'b00:   alu_f = a + b;
      2'b01:   alu_f = a - b;
      2'b10:   alu_f = a & b;
      default: alu_f = ~b;
    endcase
  endfunction

`ifdef DATAPATH_OVF_EN
  function automatic logic ovf_f(input logic [1:0] op,
                                 input logic signed [W-1:0] a,
                                 input logic signed [W-1:0] b,
                                 input logic signed [W-1:0] r);
    case (op)
      2'b00:   ovf_f = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      2'b01:   ovf_f = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      default: ovf_f = 1'b0;
    endcase
  endfunction
`endif

  logic        [W-1:0] regs [8];
  logic        [2:0]   idx;
  logic        [W-1:0] rd_data;
  logic        [W-1:0] wb_data;
  logic signed [W-1:0] reg_a;
  logic signed [W-1:0] reg_b;
  logic signed [W-1:0] reg_c;
  logic signed [W-1:0] ain;
  logic signed [W-1:0] bin;
  logic signed [W-1:0] alu_res;
  logic                z_q;
  logic                n_q;

  // Read and write share the index chosen by nsel in a given cycle.
  always_comb begin
    idx = 3'd0;
    case (nsel)
      3'b100:  idx = rn;
      3'b010:  idx = rd;
      3'b001:  idx = rm;
      default: idx = 3'd0;
    endcase
  end

  assign rd_data = regs[idx];

  always_comb begin
    wb_data = reg_c;
    case (vsel)
      2'b00:   wb_data = reg_c;
      2'b01:   wb_data = sximm8;
      2'b10:   wb_data = mdata;
      default: wb_data = {{(W-8){1'b0}}, pc};
    endcase
  end

  assign ain     = asel ? '0 : reg_a;
  assign bin     = bsel ? sximm5 : shift_f(shift, reg_b);
  assign alu_res = alu_f(aluop, ain, bin);

  // ---- stage boundary: register file and A/B operand registers ----
  // Both the read port feeding A/B and the write port act on the same edge,
  // so A/B see the pre-write contents (read-before-write).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      if (write) regs[idx] <= wb_data;
      if (loada) reg_a     <= rd_data;
      if (loadb) reg_b     <= rd_data;
    end
  end

  // ---- stage boundary: result register C and status flags ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_c <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      if (loadc) reg_c <= alu_res;
      if (loads) begin
        z_q <= (alu_res == '0);
        n_q <= alu_res[W-1];
      end
    end
  end

`ifdef DATAPATH_OVF_EN
  logic v_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= 1'b0;
    end else if (loads) begin
      v_q <= ovf_f(aluop, ain, bin, alu_res);
    end
  end

  assign V_out = v_q;
`else
  assign V_out = 1'b0;
`endif

  assign datapath_out = reg_c;
  assign Z_out        = z_q;
  assign N_out        = n_q;

endmodule

// File: tb/tb_datapath_unit.sv
module tb_datapath_unit;

`ifdef DATAPATH_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  nsel, rn, rd, rm;
  logic [1:0]  vsel;
  logic        write, loada, loadb, asel, bsel, loadc, loads;
  logic [1:0]  shift, aluop;
  logic [15:0] sximm8, sximm5, mdata;
  logic [7:0]  pc;
  logic [15:0] datapath_out;
  logic        Z_out, N_out, V_out;

  typedef struct packed {
    logic [15:0] c;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  obs = 1'b0;
  int    checks = 0;
  int    errors = 0;

  datapath_unit #(.W(16)) dut (
    .clk(clk), .reset_n(reset_n), .nsel(nsel), .rn(rn), .rd(rd), .rm(rm),
    .vsel(vsel), .write(write), .loada(loada), .loadb(loadb), .asel(asel),
    .bsel(bsel), .shift(shift), .aluop(aluop), .loadc(loadc), .loads(loads),
    .sximm8(sximm8), .sximm5(sximm5), .mdata(mdata), .pc(pc),
    .datapath_out(datapath_out), .Z_out(Z_out), .N_out(N_out), .V_out(V_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: whenever the driver flagged a C capture, compare against the queue.
  initial begin
    logic  o;
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      o = obs;
      #1;
      if (o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow actual=empty expected=entry");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          chk({nm, "_C"}, datapath_out, e.c);
          chk({nm, "_Z"}, {15'd0, Z_out}, {15'd0, e.z});
          chk({nm, "_N"}, {15'd0, N_out}, {15'd0, e.n});
          chk({nm, "_V"}, {15'd0, V_out}, {15'd0, e.v});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    nsel = 3'b000; rn = 0; rd = 0; rm = 0; vsel = 2'b00;
    write = 0; loada = 0; loadb = 0; asel = 0; bsel = 0;
    shift = 2'b00; aluop = 2'b00; loadc = 0; loads = 0;
    sximm8 = 0; sximm5 = 0; mdata = 0; pc = 0; obs = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    idle();
  endtask

  task automatic wr_imm(input logic [2:0] r, input logic [15:0] v);
    nsel = 3'b010; rd = r; vsel = 2'b01; sximm8 = v; write = 1;
    tick();
  endtask

  task automatic ld_a(input logic [2:0] r);
    nsel = 3'b100; rn = r; loada = 1;
    tick();
  endtask

  task automatic ld_b(input logic [2:0] r);
    nsel = 3'b100; rn = r; loadb = 1;
    tick();
  endtask

  // Leaves any write/vsel/nsel already set by the caller in place for the edge.
  task automatic exec(input string nm, input logic as, input logic bs,
                      input logic [1:0] sh, input logic [1:0] op,
                      input logic [15:0] imm5, input logic ls,
                      input logic [15:0] ec, input logic ez, input logic en,
                      input logic ev);
    exp_t e;
    asel = as; bsel = bs; shift = sh; aluop = op; sximm5 = imm5;
    loadc = 1; loads = ls; obs = 1;
    e.c = ec; e.z = ez; e.n = en; e.v = ev;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
  endtask

  initial begin
    idle();
    reset_n = 0;
    @(posedge clk); #1;
    chk("rst_C", datapath_out, 16'h0000);
    chk("rst_Z", {15'd0, Z_out}, 16'd0);
    chk("rst_N", {15'd0, N_out}, 16'd0);
    chk("rst_V", {15'd0, V_out}, 16'd0);
    #1;
    reset_n = 1;
    @(posedge clk); #2;

    // Asynchronous reset mid-run
    wr_imm(3, 16'h1234);
    ld_a(3);
    exec("r3_pre", 0, 1, 2'b00, 2'b00, 16'h0000, 1, 16'h1234, 0, 0, 0);
    exec("neg_pre", 1, 1, 2'b00, 2'b01, 16'h0001, 1, 16'hFFFF, 0, 1, 0);
    reset_n = 0;
    #1;
    chk("arst_C", datapath_out, 16'h0000);
    chk("arst_Z", {15'd0, Z_out}, 16'd0);
    chk("arst_N", {15'd0, N_out}, 16'd0);
    chk("arst_V", {15'd0, V_out}, 16'd0);
    @(posedge clk); #2;
    reset_n = 1;
    ld_a(3);
    exec("r3_post", 0, 1, 2'b00, 2'b00, 16'h0000, 1, 16'h0000, 1, 0, 0);

    // 2 + (7 << 1)
    wr_imm(0, 16'h0007);
    wr_imm(1, 16'h0002);
    ld_a(1);
    ld_b(0);
    exec("add_lsl", 0, 0, 2'b01, 2'b00, 16'h0000, 1, 16'h0010, 0, 0, 0);

    // Signed ADD overflow
    wr_imm(4, 16'h7FFF);
    wr_imm(5, 16'h0001);
    ld_a(4);
    ld_b(5);
    exec("add_ovf", 0, 0, 2'b00, 2'b00, 16'h0000, 1, 16'h8000, 0, 1, OVF);

    // AND to zero, then shifts into NOT
    wr_imm(4, 16'h00F0);
    wr_imm(5, 16'h0F0F);
    ld_a(4);
    ld_b(5);
    exec("and_zero", 0, 0, 2'b00, 2'b10, 16'h0000, 1, 16'h0000, 1, 0, 0);
    wr_imm(6, 16'h8000);
    ld_b(6);
    exec("asr_not", 0, 0, 2'b11, 2'b11, 16'h0000, 1, 16'h3FFF, 0, 0, 0);
    exec("lsr_not", 0, 0, 2'b10, 2'b11, 16'h0000, 1, 16'hBFFF, 0, 1, 0);
    // loads low: flags hold previous values
    exec("hold_flags", 0, 0, 2'b00, 2'b11, 16'h0000, 0, 16'h7FFF, 0, 1, 0);

    // Signed SUB overflow: 0x8000 - 1
    wr_imm(5, 16'h0001);
    ld_a(6);
    ld_b(5);
    exec("sub_ovf", 0, 0, 2'b00, 2'b01, 16'h0000, 1, 16'h7FFF, 0, 0, OVF);

    // Read-before-write on the same register
    wr_imm(2, 16'h0005);
    nsel = 3'b100; rn = 2; vsel = 2'b10; mdata = 16'h00AA; write = 1; loada = 1;
    tick();
    exec("rbw_old", 0, 1, 2'b00, 2'b00, 16'h0000, 1, 16'h0005, 0, 0, 0);
    ld_a(2);
    exec("rbw_new", 0, 1, 2'b00, 2'b00, 16'h0000, 1, 16'h00AA, 0, 0, 0);

    // Ain=0, Bin=sximm5: 0 - (-3)
    exec("sub_imm", 1, 1, 2'b00, 2'b01, 16'hFFFD, 1, 16'h0003, 0, 0, 0);

    // pc write-back
    nsel = 3'b010; rd = 7; vsel = 2'b11; pc = 8'h42; write = 1;
    tick();
    ld_a(7);
    exec("pc_wb", 0, 1, 2'b00, 2'b00, 16'h0000, 1, 16'h0042, 0, 0, 0);

    // loadc with vsel=C write in same cycle: R1 gets old C (0x0042)
    nsel = 3'b010; rd = 1; vsel = 2'b00; write = 1;
    exec("c_new", 1, 1, 2'b00, 2'b00, 16'h0005, 1, 16'h0005, 0, 0, 0);
    ld_a(1);
    exec("c_old_wb", 0, 1, 2'b00, 2'b00, 16'h0000, 1, 16'h0042, 0, 0, 0);

    // Non one-hot nsel selects R0 (holds 7)
    nsel = 3'b011; rn = 5; rd = 5; rm = 5; loada = 1;
    tick();
    exec("nsel_r0", 0, 1, 2'b00, 2'b00, 16'h0000, 1, 16'h0007, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
